// File: rtl/seq_run_logger.sv
// seq_run_logger
//   Turns the run detector's level flag into discrete run events. Each run is
//   classified as a 0-run or 1-run, its length in cycles is measured, and
//   saturating statistics are kept. Completed runs are queued in a small
//   show-ahead FIFO for a slow reader.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   detect       registered detector flag (high while a run of >= 4 lasts)
//   w            the bit stream feeding the detector
//   clear        synchronous clear of statistics and FIFO
//   rd_en        pop the FIFO head (ignored while empty)
//   event_pulse  one-cycle strobe in the cycle a run starts
//   zeros_cnt    number of 0-runs started (saturating)
//   ones_cnt     number of 1-runs started (saturating)
//   max_len      longest completed run length
//   fifo_dout    head entry {type, len}, 0 while empty
//   fifo_count   FIFO occupancy
//   fifo_empty   FIFO empty
//   fifo_full    FIFO full
//   overflow     sticky: a completed run was dropped on a full FIFO
module seq_run_logger #(
  parameter int LEN_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     detect,
  input  logic                     w,
  input  logic                     clear,
  input  logic                     rd_en,
  output logic                     event_pulse,
  output logic [LEN_W-1:0]         zeros_cnt,
  output logic [LEN_W-1:0]         ones_cnt,
  output logic [LEN_W-1:0]         max_len,
  output logic [LEN_W:0]           fifo_dout,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] LEN_MAX  = '1;
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic               detect_d;
  logic               w_d;
  logic               run_type;
  logic               in_run;
  logic [LEN_W-1:0]   run_len;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEN_W:0]     mem [DEPTH];

  logic rise;
  logic fall;
  logic push;
  logic pop;
  logic wr;

  assign rise        = detect & ~detect_d;
  // Gated by reset so the strobe stays low while reset is held.
  assign event_pulse = reset & rise;
  assign fall        = in_run & ~detect;
  assign push        = fall & ~clear;
  assign pop         = rd_en & ~fifo_empty & ~clear;
  // A push into a full FIFO succeeds only if a pop frees the head this cycle.
  assign wr          = push & (~fifo_full | pop);

  assign fifo_empty  = (fifo_count == '0);
  assign fifo_full   = (fifo_count == FULL_CNT);
  assign fifo_dout   = fifo_empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      detect_d   <= 1'b0;
      w_d        <= 1'b0;
      run_type   <= 1'b0;
      in_run     <= 1'b0;
      run_len    <= '0;
      zeros_cnt  <= '0;
      ones_cnt   <= '0;
      max_len    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      // Edge history keeps tracking through clear so a level that is still
      // high afterwards is not mistaken for a new rise.
      detect_d <= detect;
      w_d      <= w;
      if (clear) begin
        state      <= IDLE;
        in_run     <= 1'b0;
        run_type   <= 1'b0;
        run_len    <= '0;
        zeros_cnt  <= '0;
        ones_cnt   <= '0;
        max_len    <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        overflow   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state    <= RUN;
              in_run   <= 1'b1;
              // detect lags w by one flop, so w_d is the bit that completed
              // the pattern.
              run_type <= w_d;
              run_len  <= LEN_ONE;
              if (w_d) begin
                if (ones_cnt != LEN_MAX) ones_cnt <= ones_cnt + 1'b1;
              end else begin
                if (zeros_cnt != LEN_MAX) zeros_cnt <= zeros_cnt + 1'b1;
              end
            end
          end
          RUN: begin
            if (detect) begin
              if (run_len != LEN_MAX) run_len <= run_len + 1'b1;
            end else begin
              state  <= IDLE;
              in_run <= 1'b0;
              if (run_len > max_len) max_len <= run_len;
            end
          end
          default: state <= IDLE;
        endcase

        if (wr)  wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push && fifo_full && !pop) overflow <= 1'b1;

        case ({wr, pop})
          2'b10:   fifo_count <= fifo_count + 1'b1;
          2'b01:   fifo_count <= fifo_count - 1'b1;
          default: fifo_count <= fifo_count;
        endcase
      end
    end
  end

  // Storage needs no reset: fifo_dout is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= {run_type, run_len};
  end

endmodule

// File: tb/tb_seq_run_logger.sv
// Self-checking bench for seq_run_logger. Stimulus pushes the hand-computed
// FIFO entries it expects into a queue; a monitor pops and compares whenever
// the FIFO is read. Statistics are checked directly by the stimulus.
module tb_seq_run_logger;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       detect = 1'b0;
  logic       w = 1'b0;
  logic       clear = 1'b0;
  logic       rd_en = 1'b0;
  logic       event_pulse;
  logic [7:0] zeros_cnt;
  logic [7:0] ones_cnt;
  logic [7:0] max_len;
  logic [8:0] fifo_dout;
  logic [2:0] fifo_count;
  logic       fifo_empty;
  logic       fifo_full;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;
  int p0;
  logic [8:0] exp_q[$];

  seq_run_logger #(.LEN_W(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .detect(detect), .w(w), .clear(clear),
    .rd_en(rd_en), .event_pulse(event_pulse), .zeros_cnt(zeros_cnt),
    .ones_cnt(ones_cnt), .max_len(max_len), .fifo_dout(fifo_dout),
    .fifo_count(fifo_count), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts start strobes and scores every accepted pop.
  always @(negedge clk) begin
    if (event_pulse) pulse_cnt++;
    if (reset && rd_en && !fifo_empty) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no entry", fifo_dout);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if (fifo_dout !== e) begin
          errors++;
          $display("FAIL pop_entry: got 0x%0h, expected 0x%0h", fifo_dout, e);
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One cycle with detect low (idle or the previous run's fall), w set to the
  // new run's class, then detect high for len cycles. detect is left high so
  // a following run() call is back-to-back.
  task automatic run(input logic t, input int len, input bit keep, input logic [8:0] e);
    if (keep) exp_q.push_back(e);
    w = t;
    detect = 1'b0;
    step();
    detect = 1'b1;
    repeat (len) step();
  endtask

  task automatic end_run(input logic pop);
    detect = 1'b0;
    rd_en = pop;
    step();
    rd_en = 1'b0;
  endtask

  task automatic pop_n(input int n);
    rd_en = 1'b1;
    repeat (n) step();
    rd_en = 1'b0;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_q.delete();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_pulse"}, 32'(event_pulse), 32'd0);
    chk({tag, "_zeros"}, 32'(zeros_cnt), 32'd0);
    chk({tag, "_ones"},  32'(ones_cnt), 32'd0);
    chk({tag, "_max"},   32'(max_len), 32'd0);
    chk({tag, "_dout"},  32'(fifo_dout), 32'd0);
    chk({tag, "_count"}, 32'(fifo_count), 32'd0);
    chk({tag, "_empty"}, 32'(fifo_empty), 32'd1);
    chk({tag, "_full"},  32'(fifo_full), 32'd0);
    chk({tag, "_ovf"},   32'(overflow), 32'd0);
  endtask

  initial begin
    // 1. reset hold with toggling inputs
    for (int i = 0; i < 3; i++) begin
      detect = ~detect; w = ~w; clear = ~clear; rd_en = ~rd_en;
      step();
      chk_idle("rst_hold");
    end
    chk("rst_pulses", 32'(pulse_cnt), 32'd0);
    detect = 1'b0; w = 1'b0; clear = 1'b0; rd_en = 1'b0;
    step();
    reset = 1'b1;
    step();
    step();

    // 2. single 0-run of 3 cycles
    p0 = pulse_cnt;
    run(1'b0, 3, 1'b1, 9'h003);
    end_run(1'b0);
    chk("r0_pulses", 32'(pulse_cnt - p0), 32'd1);
    chk("r0_zeros", 32'(zeros_cnt), 32'd1);
    chk("r0_ones", 32'(ones_cnt), 32'd0);
    chk("r0_dout", 32'(fifo_dout), 32'h003);
    chk("r0_max", 32'(max_len), 32'd3);
    chk("r0_count", 32'(fifo_count), 32'd1);
    pop_n(1);
    chk("r0_empty", 32'(fifo_empty), 32'd1);
    pop_n(1);
    chk("pop_empty_count", 32'(fifo_count), 32'd0);
    chk("pop_empty_dout", 32'(fifo_dout), 32'd0);

    // 3. 1-run of 300 cycles saturates the length at 255
    run(1'b1, 300, 1'b1, 9'h1FF);
    end_run(1'b0);
    chk("sat_ones", 32'(ones_cnt), 32'd1);
    chk("sat_max", 32'(max_len), 32'd255);
    chk("sat_dout", 32'(fifo_dout), 32'h1FF);
    pop_n(1);

    // 4a. five runs without reads: fifth dropped
    run(1'b0, 1, 1'b1, 9'h001);
    run(1'b1, 2, 1'b1, 9'h102);
    run(1'b0, 3, 1'b1, 9'h003);
    run(1'b1, 4, 1'b1, 9'h104);
    run(1'b0, 5, 1'b0, 9'h005);
    end_run(1'b0);
    chk("ovf_full", 32'(fifo_full), 32'd1);
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_zeros", 32'(zeros_cnt), 32'd4);
    chk("ovf_ones", 32'(ones_cnt), 32'd3);
    pop_n(4);
    chk("ovf_drained", 32'(fifo_empty), 32'd1);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    do_clear();
    chk_idle("clr");

    // 4b. push and pop together while full: no overflow
    run(1'b0, 6, 1'b1, 9'h006);
    run(1'b0, 7, 1'b1, 9'h007);
    run(1'b0, 8, 1'b1, 9'h008);
    run(1'b0, 9, 1'b1, 9'h009);
    run(1'b1, 10, 1'b1, 9'h10A);
    end_run(1'b1);
    chk("pp_count", 32'(fifo_count), 32'd4);
    chk("pp_full", 32'(fifo_full), 32'd1);
    chk("pp_ovf", 32'(overflow), 32'd0);
    chk("pp_max", 32'(max_len), 32'd10);
    pop_n(4);

    // 5. clear on cycle 2 of a 6-cycle 1-run
    do_clear();
    p0 = pulse_cnt;
    w = 1'b1;
    detect = 1'b0;
    step();
    detect = 1'b1;
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (4) step();
    detect = 1'b0;
    step();
    chk("cmr_empty", 32'(fifo_empty), 32'd1);
    chk("cmr_ones", 32'(ones_cnt), 32'd0);
    chk("cmr_zeros", 32'(zeros_cnt), 32'd0);
    chk("cmr_max", 32'(max_len), 32'd0);
    chk("cmr_pulses", 32'(pulse_cnt - p0), 32'd1);
    run(1'b0, 2, 1'b1, 9'h002);
    end_run(1'b0);
    chk("cmr_next_zeros", 32'(zeros_cnt), 32'd1);
    chk("cmr_next_pulses", 32'(pulse_cnt - p0), 32'd2);
    chk("cmr_next_max", 32'(max_len), 32'd2);
    pop_n(1);

    // 6. back-to-back alternating runs
    run(1'b0, 4, 1'b1, 9'h004);
    run(1'b1, 3, 1'b1, 9'h103);
    run(1'b0, 2, 1'b1, 9'h002);
    end_run(1'b0);
    chk("b2b_count", 32'(fifo_count), 32'd3);
    chk("b2b_zeros", 32'(zeros_cnt), 32'd3);
    chk("b2b_ones", 32'(ones_cnt), 32'd1);
    pop_n(3);

    // 6b. 260 one-cycle 1-runs saturate ones_cnt
    do_clear();
    for (int i = 0; i < 260; i++) run(1'b1, 1, (i < 4), 9'h101);
    end_run(1'b0);
    chk("csat_ones", 32'(ones_cnt), 32'd255);
    chk("csat_zeros", 32'(zeros_cnt), 32'd0);
    chk("csat_ovf", 32'(overflow), 32'd1);
    chk("csat_count", 32'(fifo_count), 32'd4);
    chk("csat_max", 32'(max_len), 32'd1);
    pop_n(4);

    // 7. reset mid-run; after release detect_d and w_d restart at 0, so the
    // still-high detect is a fresh rise classified from w_d = 0.
    w = 1'b1;
    detect = 1'b0;
    step();
    detect = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    chk_idle("rst_async");
    #1;
    reset = 1'b1;
    repeat (3) step();
    detect = 1'b0;
    step();
    chk("rmr_zeros", 32'(zeros_cnt), 32'd1);
    chk("rmr_ones", 32'(ones_cnt), 32'd0);
    exp_q.push_back(9'h003);
    pop_n(1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
